// File: rtl/gcn_pkg.sv
// rtl/gcn_pkg.sv - shared FSM state encoding and host header field positions
package gcn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WDATA,
        INPUT,
        FLUSH,
        WAIT,
        HDR,
        DRAIN
    } state_t;

    localparam int HDR_ROW_MSB = 15;
    localparam int HDR_ROW_LSB = 8;
    localparam int HDR_COL_MSB = 7;
    localparam int HDR_COL_LSB = 0;

endpackage

// File: rtl/gcn_entry_fifo.sv
// rtl/gcn_entry_fifo.sv - circular entry FIFO with occupancy count
module gcn_entry_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/gcn_host_ctrl.sv
// rtl/gcn_host_ctrl.sv - host protocol front end: weight load, sparse entry stream, result drain
module gcn_host_ctrl
    import gcn_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int W_ROWS     = 32,
    parameter int N_COLS     = 2,
    parameter int OUT_ROWS   = 100,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              i_cmd,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_result,
    output logic              o_rdy,
    output logic [DATA_W-1:0] o_data,
    output logic              o_dvalid,
    output logic              o_sw,
    output logic              o_w_wr,
    output logic [7:0]        o_w_col,
    output logic [7:0]        o_w_row,
    output logic [DATA_W-1:0] o_w_data,
    output logic              o_e_valid,
    output logic [7:0]        o_e_row,
    output logic [7:0]        o_e_col,
    output logic [DATA_W-1:0] o_e_data,
    input  logic              i_e_ready,
    output logic              o_last,
    input  logic              i_done,
    output logic [15:0]       o_res_addr,
    input  logic [DATA_W-1:0] i_res_data,
    output logic              o_err
);
    localparam int         TOTAL_R  = N_COLS * OUT_ROWS;
    localparam int         EW       = 16 + DATA_W;
    localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] COL_MASK = 8'(N_COLS - 1);

    state_t            state_q, state_d;
    logic [7:0]        base_q, base_d, wrow_q, wrow_d, wcol_q, wcol_d;
    logic [7:0]        erow_q, erow_d, ecol_q, ecol_d;
    logic              hdr_q, hdr_d, rd_pend_q, rd_pend_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              result_q, result_d, rdy_q, rdy_d, dvalid_q, dvalid_d, sw_q, sw_d;
    logic              w_wr_q, w_wr_d, last_q, last_d, err_q, err_d;
    logic [7:0]        w_col_q, w_col_d, w_row_q, w_row_d;
    logic [DATA_W-1:0] data_q, data_d, w_data_q, w_data_d;

    logic              accept, w_last, in_range, fifo_push, fifo_pop, push_ok;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [EW-1:0]     fifo_head;

    assign accept    = (state_q == IDLE) && i_req && result_q;
    assign w_last    = (wcol_q == 8'(N_COLS - 1)) && (wrow_q == 8'(W_ROWS - 1));
    assign in_range  = (int'(erow_q) < OUT_ROWS) && (int'(ecol_q) < W_ROWS);
    assign fifo_push = (state_q == INPUT) && hdr_q && in_range;
    assign fifo_pop  = !fifo_empty && i_e_ready;
    assign push_ok   = fifo_push && (!fifo_full || fifo_pop);

    gcn_entry_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i ({erow_q, ecol_q, i_data}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = WADDR;
            WADDR:   state_d = WDATA;
            WDATA:   if (w_last) state_d = INPUT;
            INPUT:   if (i_cmd) state_d = FLUSH;
            FLUSH:   if (fifo_count == '0) state_d = WAIT;
            WAIT:    if (i_done) state_d = HDR;
            HDR:     state_d = DRAIN;
            DRAIN:   if (cnt_q == 16'(TOTAL_R + 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The drain runs two cycles past the last address so the read pipeline empties before o_rdy.
    always_comb begin
        base_d    = base_q;
        wrow_d    = wrow_q;
        wcol_d    = wcol_q;
        erow_d    = erow_q;
        ecol_d    = ecol_q;
        hdr_d     = hdr_q;
        cnt_d     = cnt_q;
        rd_pend_d = (state_q == DRAIN) && (cnt_q < 16'(TOTAL_R));
        result_d  = (state_q == IDLE) && (state_d == IDLE);
        rdy_d     = 1'b0;
        sw_d      = 1'b0;
        w_wr_d    = 1'b0;
        w_col_d   = w_col_q;
        w_row_d   = w_row_q;
        w_data_d  = w_data_q;
        data_d    = data_q;
        dvalid_d  = 1'b0;
        last_d    = 1'b0;
        err_d     = err_q;
        unique case (state_q)
            IDLE: if (accept) err_d = 1'b0;
            WADDR: begin
                base_d = i_data[7:0] & ~COL_MASK;
                if ((i_data[7:0] & COL_MASK) != '0) err_d = 1'b1;
                sw_d   = 1'b1;
                wrow_d = '0;
                wcol_d = '0;
                hdr_d  = 1'b0;
            end
            WDATA: begin
                w_wr_d   = 1'b1;
                w_col_d  = base_q + wcol_q;
                w_row_d  = wrow_q;
                w_data_d = i_data;
                if (wrow_q == 8'(W_ROWS - 1)) begin
                    wrow_d = '0;
                    wcol_d = wcol_q + 8'd1;
                end else begin
                    wrow_d = wrow_q + 8'd1;
                end
            end
            INPUT: begin
                hdr_d = !hdr_q;
                if (!hdr_q) begin
                    erow_d = i_data[HDR_ROW_MSB:HDR_ROW_LSB];
                    ecol_d = i_data[HDR_COL_MSB:HDR_COL_LSB];
                    if (i_cmd) err_d = 1'b1;
                end else if (!push_ok) begin
                    err_d = 1'b1;
                end
            end
            FLUSH: if (fifo_count == '0) last_d = 1'b1;
            WAIT: ;
            HDR: begin
                data_d   = DATA_W'(base_q);
                dvalid_d = 1'b1;
                cnt_d    = '0;
            end
            DRAIN: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == 16'(TOTAL_R + 1)) rdy_d = 1'b1;
            end
            default: ;
        endcase
        if (rd_pend_q) begin
            data_d   = i_res_data;
            dvalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            base_q <= '0;  wrow_q <= '0;  wcol_q <= '0;  erow_q <= '0;  ecol_q <= '0;
            hdr_q <= 1'b0; cnt_q <= '0;   rd_pend_q <= 1'b0;
            result_q <= 1'b0; rdy_q <= 1'b0; sw_q <= 1'b0; w_wr_q <= 1'b0;
            w_col_q <= '0; w_row_q <= '0; w_data_q <= '0; data_q <= '0;
            dvalid_q <= 1'b0; last_q <= 1'b0; err_q <= 1'b0;
        end else begin
            base_q <= base_d;  wrow_q <= wrow_d;  wcol_q <= wcol_d;  erow_q <= erow_d;  ecol_q <= ecol_d;
            hdr_q <= hdr_d;    cnt_q <= cnt_d;    rd_pend_q <= rd_pend_d;
            result_q <= result_d; rdy_q <= rdy_d; sw_q <= sw_d; w_wr_q <= w_wr_d;
            w_col_q <= w_col_d; w_row_q <= w_row_d; w_data_q <= w_data_d; data_q <= data_d;
            dvalid_q <= dvalid_d; last_q <= last_d; err_q <= err_d;
        end
    end

    // Addresses step linearly, which equals col_offset*OUT_ROWS + row.
    assign o_res_addr = ((state_q == DRAIN) && (cnt_q < 16'(TOTAL_R))) ? cnt_q : '0;
    assign o_result   = result_q;
    assign o_rdy      = rdy_q;
    assign o_data     = data_q;
    assign o_dvalid   = dvalid_q;
    assign o_sw       = sw_q;
    assign o_w_wr     = w_wr_q;
    assign o_w_col    = w_col_q;
    assign o_w_row    = w_row_q;
    assign o_w_data   = w_data_q;
    assign o_last     = last_q;
    assign o_err      = err_q;
    assign o_e_valid  = !fifo_empty;
    assign o_e_row    = fifo_empty ? '0 : fifo_head[EW-1 -: 8];
    assign o_e_col    = fifo_empty ? '0 : fifo_head[DATA_W+7 -: 8];
    assign o_e_data   = fifo_empty ? '0 : fifo_head[DATA_W-1:0];

endmodule
